// File: rtl/logic_op_pipe_pkg.sv
// Shared types and the bitwise operation used by both the combinational
// output and the stage-0 load of logic_op_pipe.
package logic_op_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  // Evaluated at full width; callers truncate to their own operand width.
  function automatic logic [MAX_WIDTH-1:0] apply_op(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input op_e                  op
  );
    logic [MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_pipe_stage.sv
// One pipeline register: a valid bit plus WIDTH data bits, loaded when en=1,
// held otherwise, cleared by synchronous reset.
module logic_op_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Bitwise logic unit with a combinational result and a STAGES-deep
// valid/ready pipelined result, plus a saturating count of output transfers.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_comb,
  output logic [WIDTH-1:0] out_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      done_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipeline advances together (en) whenever the last stage is
  // empty or being drained; in_ready is that same enable, so a producer may
  // hold valid high and must keep its data stable until it sees in_ready.
  logic                   en;
  logic                   out_xfer;
  logic [STAGES:0]        stage_valid;
  logic [STAGES:0][WIDTH-1:0] stage_data;

  assign out_comb = WIDTH'(apply_op(MAX_WIDTH'(a), MAX_WIDTH'(b), op_e'(op)));

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign out_xfer = out_valid && out_ready;

  // Index 0 is the incoming transaction; index STAGES is the last register.
  assign stage_valid[0] = in_valid;
  assign stage_data[0]  = out_comb;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic_op_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (stage_valid[i]),
      .in_data   (stage_data[i]),
      .out_valid (stage_valid[i+1]),
      .out_data  (stage_data[i+1])
    );
  end

  assign out_valid = stage_valid[STAGES];
  assign out_reg   = stage_data[STAGES];

  // Reset takes priority, so a transfer coinciding with reset is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (out_xfer && (done_cnt != 16'hFFFF)) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: combinational truth tables, streaming,
// backpressure, bubbles, mid-flight reset and done_cnt saturation.
module tb_logic_op_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance (main pipeline)
  logic [7:0]  a, b;
  logic [1:0]  op;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  out_comb, out_reg;
  logic [15:0] done_cnt;

  // WIDTH=1 instance (comb sweep)
  logic        a1, b1, in_ready1, out_valid1;
  logic [1:0]  op1;
  logic        out_comb1, out_reg1;
  logic [15:0] done_cnt1;

  logic_op_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_comb(out_comb), .out_reg(out_reg), .out_valid(out_valid),
    .out_ready(out_ready), .done_cnt(done_cnt)
  );

  logic_op_pipe #(.WIDTH(1), .STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .op(op1),
    .in_valid(1'b0), .in_ready(in_ready1),
    .out_comb(out_comb1), .out_reg(out_reg1), .out_valid(out_valid1),
    .out_ready(1'b1), .done_cnt(done_cnt1)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic        last_acc;

  typedef struct {
    logic       w1;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[24];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } item_t;

  item_t items[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one cycle and scores transfers.
  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [1:0] iop, input logic ordy);
    logic [7:0] e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    out_ready = ordy;
    #1;
    last_acc = iv && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_reg), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_order", 32'(out_reg), 32'(e));
      end
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    if (last_acc) exp_q.push_back(model_op(ia, ib, iop));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
  endtask

  // ---------------- test ----------------
  logic [7:0] held;
  int         k, n;
  logic       bub_iv[5];
  logic       bub_ov[5];

  initial begin
    vecs = '{
      '{1'b1, 8'h0, 8'h0, 2'd0, 8'h0}, '{1'b1, 8'h0, 8'h1, 2'd0, 8'h0},
      '{1'b1, 8'h1, 8'h0, 2'd0, 8'h0}, '{1'b1, 8'h1, 8'h1, 2'd0, 8'h1},
      '{1'b1, 8'h0, 8'h0, 2'd1, 8'h0}, '{1'b1, 8'h0, 8'h1, 2'd1, 8'h1},
      '{1'b1, 8'h1, 8'h0, 2'd1, 8'h1}, '{1'b1, 8'h1, 8'h1, 2'd1, 8'h1},
      '{1'b1, 8'h0, 8'h0, 2'd2, 8'h0}, '{1'b1, 8'h0, 8'h1, 2'd2, 8'h1},
      '{1'b1, 8'h1, 8'h0, 2'd2, 8'h1}, '{1'b1, 8'h1, 8'h1, 2'd2, 8'h0},
      '{1'b1, 8'h0, 8'h0, 2'd3, 8'h1}, '{1'b1, 8'h0, 8'h1, 2'd3, 8'h1},
      '{1'b1, 8'h1, 8'h0, 2'd3, 8'h1}, '{1'b1, 8'h1, 8'h1, 2'd3, 8'h0},
      '{1'b0, 8'hA5, 8'h3C, 2'd0, 8'h24}, '{1'b0, 8'hA5, 8'h3C, 2'd1, 8'hBD},
      '{1'b0, 8'hA5, 8'h3C, 2'd2, 8'h99}, '{1'b0, 8'hA5, 8'h3C, 2'd3, 8'hDB},
      '{1'b0, 8'hFF, 8'h0F, 2'd0, 8'h0F}, '{1'b0, 8'hFF, 8'h0F, 2'd1, 8'hFF},
      '{1'b0, 8'hFF, 8'h0F, 2'd2, 8'hF0}, '{1'b0, 8'hFF, 8'h0F, 2'd3, 8'hF0}
    };
    items = '{'{8'h11, 8'h22, 2'd1}, '{8'h0F, 8'hF0, 2'd2}, '{8'hC3, 8'h81, 2'd3}};
    bub_iv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bub_ov = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b1;
    a1 = 1'b0; b1 = 1'b0; op1 = '0;
    @(posedge clk); #1;

    // comb sweep with rst still high: out_comb must stay combinational
    for (int i = 0; i < 24; i++) begin
      a1 = vecs[i].a[0]; b1 = vecs[i].b[0]; op1 = vecs[i].op;
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
      #1;
      if (vecs[i].w1) check($sformatf("comb1_%0d", i), 32'(out_comb1), 32'(vecs[i].exp[0]));
      else            check($sformatf("comb8_%0d", i), 32'(out_comb), 32'(vecs[i].exp));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_reg", 32'(out_reg), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // streaming with an op change between consecutive items
    step(1'b1, 8'hA5, 8'h3C, 2'd0, 1'b1);
    check("stream_lat1_valid", 32'(out_valid), 32'd0);
    step(1'b1, 8'hA5, 8'h3C, 2'd2, 1'b1);
    check("stream_first_valid", 32'(out_valid), 32'd1);
    check("stream_first_data", 32'(out_reg), 32'h24);
    step(1'b0, 8'h00, 8'h00, 2'd1, 1'b1);
    check("stream_second_valid", 32'(out_valid), 32'd1);
    check("stream_second_data", 32'(out_reg), 32'h99);
    step(1'b0, 8'h00, 8'h00, 2'd1, 1'b1);
    check("stream_drained", 32'(out_valid), 32'd0);
    check("stream_done_cnt", 32'(done_cnt), 32'd2);

    // backpressure: out_ready low for 5 cycles while 3 items are offered
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, items[k].a, items[k].b, items[k].op, 1'b0);
      if (last_acc) k++;
      if (c >= 1) begin
        check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
        check($sformatf("bp_hold_%0d", c), 32'(out_reg), 32'h33);
      end
    end
    check("bp_accepted_while_stalled", 32'(k), 32'd2);
    n = 0;
    while ((k < 3 || exp_q.size() != 0) && n < 20) begin
      if (k < 3) step(1'b1, items[k].a, items[k].b, items[k].op, 1'b1);
      else       step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      if (last_acc) k++;
      n++;
    end
    check("bp_drain_timeout", 32'(n < 20), 32'd1);
    check("bp_all_out", 32'(exp_q.size()), 32'd0);
    check("bp_done_cnt", 32'(done_cnt), 32'd5);

    // bubble pattern 1,0,1 must emerge as 1,0,1
    for (int i = 0; i < 5; i++) begin
      step(bub_iv[i], 8'h5A, 8'h0F + 8'(i), 2'd2, 1'b1);
      check($sformatf("bubble_ov_%0d", i), 32'(out_valid), 32'(bub_ov[i]));
    end
    check("bubble_done_cnt", 32'(done_cnt), 32'd7);

    // reset with two items in flight; a new item is offered on the reset edge
    step(1'b1, 8'hF0, 8'h3C, 2'd0, 1'b0);
    step(1'b1, 8'hF0, 8'h3C, 2'd1, 1'b0);
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; out_ready = 1'b1;
    do_reset();
    in_valid = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_out_reg", 32'(out_reg), 32'd0);
    check("mid_done_cnt", 32'(done_cnt), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      check($sformatf("mid_no_stale_%0d", i), 32'(out_valid), 32'd0);
    end
    check("mid_done_cnt_after", 32'(done_cnt), 32'd0);

    // saturation: 65537 transfers
    for (int i = 0; i < 65537; i++) begin
      step(1'b1, 8'(i), 8'(i >> 8), 2'(i), 1'b1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      n++;
    end
    check("sat_drain", 32'(exp_q.size()), 32'd0);
    check("sat_model_cnt", 32'(exp_cnt), 32'hFFFF);
    check("sat_done_cnt", 32'(done_cnt), 32'hFFFF);
    step(1'b1, 8'h01, 8'h01, 2'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    check("sat_stays", 32'(done_cnt), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits (legal range 1..32).
REQ-002 Parameter STAGES, default 2, SHALL set the number of pipeline register stages (legal range 1..4).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port a, input, WIDTH bits, SHALL be operand A.
REQ-006 Port b, input, WIDTH bits, SHALL be operand B.
REQ-007 Port op, input, 2 bits, SHALL select the operation: 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-008 Port in_valid, input, 1 bit, SHALL indicate that a, b and op are valid.
REQ-009 Port in_ready, output, 1 bit, SHALL indicate that the block accepts the input this cycle.
REQ-010 Port out_comb, output, WIDTH bits, SHALL be the combinational result of op applied to a and b.
REQ-011 Port out_reg, output, WIDTH bits, SHALL be the pipelined result.
REQ-012 Port out_valid, output, 1 bit, SHALL qualify out_reg.
REQ-013 Port out_ready, input, 1 bit, SHALL indicate that the downstream consumer accepts out_reg.
REQ-014 Port done_cnt, output, 16 bits, SHALL count completed output transfers.

Function
REQ-015 out_comb SHALL depend only on a, b and op, with no register, and SHALL be independent of in_valid, clk and rst.
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 Pipeline enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en.
REQ-018 When en=1, every stage SHALL shift forward, with stage 0 loading {in_valid, op(a,b)}.
REQ-019 When en=0, all stages SHALL hold their data and valid bits.
REQ-020 With out_ready held at 1, latency from input transfer to out_valid SHALL be exactly STAGES cycles, and throughput SHALL be 1 result per cycle.
REQ-021 Bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages; there SHALL be no bubble collapsing.
REQ-022 out_reg and out_valid SHALL be driven from the last stage.
REQ-023 out_reg SHALL hold its value while out_valid=1 and out_ready=0.
REQ-024 done_cnt SHALL increment by 1 on each output transfer and SHALL saturate at 16'hFFFF.
REQ-025 The operation SHALL be captured together with its operands at input transfer, so an op change mid-flight SHALL NOT affect results already in flight.
REQ-026 Results SHALL leave the pipeline in the order they entered it, with no loss and no duplication under any out_ready pattern.

Reset
REQ-027 While rst=1 at a clock edge, all stage valid bits SHALL clear to 0, stage data SHALL clear to 0, and done_cnt SHALL clear to 0.
REQ-028 After that reset edge, out_valid=0 and out_reg=0; in_ready=1 follows from REQ-017.
REQ-029 rst asserted mid-operation SHALL discard all in-flight data, and no output transfer SHALL be counted on that edge.
REQ-030 out_comb SHALL remain combinational during reset.

Structure
REQ-031 Package logic_op_pkg SHALL hold the op_e enum (OP_AND, OP_OR, OP_XOR, OP_NAND) and function apply_op(a, b, op).
REQ-032 Sub-module logic_op_stage (one valid bit plus WIDTH data, with enable and synchronous reset) SHALL be instantiated STAGES times via generate.
REQ-033 The top level SHALL contain the enable logic, done_cnt, and the out_comb computation.

Verification
REQ-034 Bench scenario, comb sweep: WIDTH=1, all four a/b combinations × four op values -> out_comb equals the truth table (AND 0001, OR 0111, XOR 0110, NAND 1110 for ab=00,01,10,11).
REQ-035 Bench scenario, streaming: WIDTH=8, STAGES=2, out_ready=1, inputs (A5,3C,AND),(A5,3C,XOR) on consecutive cycles -> out_reg 24 then 99, appearing 2 cycles later on consecutive cycles; done_cnt=2.
REQ-036 Bench scenario, backpressure: out_ready=0 for 5 cycles with 3 items streamed -> in_ready=0 once the pipeline is full, out_reg held stable; on release all items emerge in order with none lost.
REQ-037 Bench scenario, bubble: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 after STAGES cycles.
REQ-038 Bench scenario, reset mid-flight: rst pulsed for 1 cycle with 2 items in flight -> next cycle out_valid=0, out_reg=0, done_cnt=0, and no stale item ever appears.
REQ-039 Bench scenario, saturation: done_cnt forced near its limit via 65,537 transfers -> done_cnt stays at FFFF.
